mdu_ctrl: RTL

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl_pkg.sv | 33 +++
 rtl/mdu_ctrl_calc.sv | 78 +++++++
 rtl/mdu_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: shared constants for the multiply/divide unit.
//   - md_op encodings (MULT, MULTU, DIV, DIVU, MTHI, MTLO; 6-7 reserved)
//   - FSM state encoding
//   - default busy-cycle counts and counter width
//   - small decode helpers used by both the controller and md_calc
package mdu_ctrl_pkg;

    localparam int CNT_W            = 4;
    localparam int DEF_MULT_CYCLES  = 5;
    localparam int DEF_DIV_CYCLES   = 10;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    // Multi-cycle ops are exactly the encodings 0..3.
    function automatic logic is_long_op(input logic [2:0] op);
        return (op <= OP_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_calc.sv
// md_calc: purely combinational arithmetic for the MDU.
// Ports:
//   op  [2:0]  operation (only MULT/MULTU/DIV/DIVU produce a result)
//   a   [31:0] operand 1 (multiplicand / dividend)
//   b   [31:0] operand 2 (multiplier / divisor)
//   hi  [31:0] high product word or remainder
//   lo  [31:0] low product word or quotient
//   wr         1 when hi/lo should be committed (0 for divide-by-zero)
module md_calc
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        wr
);

    logic [31:0]        safe_b;
    logic signed [63:0] sa64;
    logic signed [63:0] sb64;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic               div_ovf;

    always_comb begin
        // A zero divisor is replaced so the dividers never see it; the
        // result is discarded through wr anyway.
        safe_b  = (b == 32'd0) ? 32'd1 : b;
        sa64    = {{32{a[31]}}, a};
        sb64    = {{32{b[31]}}, b};
        prod_s  = sa64 * sb64;
        prod_u  = {32'd0, a} * {32'd0, b};
        sa      = a;
        sb      = safe_b;
        quo_s   = sa / sb;
        rem_s   = sa % sb;
        // Most-negative / -1 overflows; pin the architectural answer.
        div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

        hi = 32'd0;
        lo = 32'd0;
        wr = 1'b0;
        case (op)
            OP_MULT: begin
                hi = prod_s[63:32];
                lo = prod_s[31:0];
                wr = 1'b1;
            end
            OP_MULTU: begin
                hi = prod_u[63:32];
                lo = prod_u[31:0];
                wr = 1'b1;
            end
            OP_DIV: begin
                hi = div_ovf ? 32'd0 : rem_s;
                lo = div_ovf ? 32'h8000_0000 : quo_s;
                wr = (b != 32'd0);
            end
            OP_DIVU: begin
                hi = a % safe_b;
                lo = a / safe_b;
                wr = (b != 32'd0);
            end
            default: begin
                hi = 32'd0;
                lo = 32'd0;
                wr = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller with architectural HI/LO.
// Ports:
//   clk, reset     clock and asynchronous active-high reset
//   start, md_op   one-cycle launch request and its operation code
//   A, B           operands (A is also the MTHI/MTLO source)
//   busy           high while a multi-cycle operation is in flight
//   HI, LO         architectural result registers
//   dbg_state      current FSM state (observation only)
//   dbg_cnt        current busy down-counter value (observation only)
// Handshake: a request is taken on a rising edge where start=1 and busy=0;
// any start seen while busy=1 is dropped without effect. The result is
// computed at acceptance and held privately until the counter expires,
// so HI/LO never show it early and a reset in flight discards it.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [31:0]      A,
    input  logic [31:0]      B,
    output logic             busy,
    output logic [31:0]      HI,
    output logic [31:0]      LO,
    output mdu_state_e       dbg_state,
    output logic [CNT_W-1:0] dbg_cnt
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    mdu_state_e       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [31:0]      hi_q, hi_n, lo_q, lo_n;
    logic [31:0]      pend_hi, pend_hi_n, pend_lo, pend_lo_n;
    logic             pend_wr, pend_wr_n;

    logic [31:0]      calc_hi;
    logic [31:0]      calc_lo;
    logic             calc_wr;

    md_calc u_calc (
        .op (md_op),
        .a  (A),
        .b  (B),
        .hi (calc_hi),
        .lo (calc_lo),
        .wr (calc_wr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            hi_q    <= hi_n;
            lo_q    <= lo_n;
            pend_hi <= pend_hi_n;
            pend_lo <= pend_lo_n;
            pend_wr <= pend_wr_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        hi_n      = hi_q;
        lo_n      = lo_q;
        pend_hi_n = pend_hi;
        pend_lo_n = pend_lo;
        pend_wr_n = pend_wr;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (is_long_op(md_op)) begin
                        pend_hi_n = calc_hi;
                        pend_lo_n = calc_lo;
                        pend_wr_n = calc_wr;
                        cnt_n     = is_div_op(md_op) ? DIV_LOAD : MULT_LOAD;
                        state_n   = ST_BUSY;
                    end else if (md_op == OP_MTHI) begin
                        hi_n = A;
                    end else if (md_op == OP_MTLO) begin
                        lo_n = A;
                    end
                end
            end
            ST_BUSY: begin
                // cnt==1 is the last busy cycle; <= also covers a zero load.
                if (cnt <= 1) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                    if (pend_wr) begin
                        hi_n = pend_hi;
                        lo_n = pend_lo;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign busy      = (state == ST_BUSY);
    assign HI        = hi_q;
    assign LO        = lo_q;
    assign dbg_state = state;
    assign dbg_cnt   = cnt;

endmodule
